// File: rtl/uvmt_cv32e40x_obi_arbiter.sv
// uvmt_cv32e40x_obi_arbiter
// Two-to-one OBI arbiter: shares one memory-side OBI port between the
// instruction fetch and data ports. Address phases are arbitrated
// round-robin (or fixed data priority when UVMT_OBI_ARB_DATA_PRIO_EN is
// defined). An in-order source FIFO routes each response back to the
// requester that issued it.
module uvmt_cv32e40x_obi_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      i_req_i,
    output logic                      i_gnt_o,
    input  logic [ADDR_WIDTH-1:0]     i_addr_i,
    output logic                      i_rvalid_o,
    input  logic                      d_req_i,
    output logic                      d_gnt_o,
    input  logic [ADDR_WIDTH-1:0]     d_addr_i,
    input  logic                      d_we_i,
    input  logic [DATA_WIDTH/8-1:0]   d_be_i,
    input  logic [DATA_WIDTH-1:0]     d_wdata_i,
    output logic                      d_rvalid_o,
    output logic [DATA_WIDTH-1:0]     r_rdata_o,
    output logic                      r_err_o,
    output logic                      m_req_o,
    input  logic                      m_gnt_i,
    output logic [ADDR_WIDTH-1:0]     m_addr_o,
    output logic                      m_we_o,
    output logic [DATA_WIDTH/8-1:0]   m_be_o,
    output logic [DATA_WIDTH-1:0]     m_wdata_o,
    output logic                      m_src_o,
    input  logic                      m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     m_rdata_i,
    input  logic                      m_err_i,
    output logic                      err_unexpected_o
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        ST_ARB,
        ST_HOLD
    } state_e;

    state_e             state_q, state_d;
    logic               hold_src_q, hold_src_d;
    logic               last_src_q, last_src_d;
    logic               fifo_q [MAX_OUTSTANDING];
    logic               fifo_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_unexpected_q, err_unexpected_d;

    logic sel_src;
    logic sel_req;
    logic full;
    logic grant;
    logic pop;
    logic head_src;

    // Source selection, address-phase handshake and payload mux
    always_comb begin
        sel_src = 1'b0;
        if (state_q == ST_HOLD) begin
            sel_src = hold_src_q;
        end else if (i_req_i && d_req_i) begin
`ifdef UVMT_OBI_ARB_DATA_PRIO_EN
            sel_src = 1'b1;
`else
            sel_src = ~last_src_q;
`endif
        end else begin
            sel_src = d_req_i;
        end

        sel_req = sel_src ? d_req_i : i_req_i;
        full    = (count_q == CNT_FULL);
        m_req_o = sel_req & ~full & ~rst_i;
        grant   = m_req_o & m_gnt_i;
        i_gnt_o = grant & ~sel_src;
        d_gnt_o = grant & sel_src;
        m_src_o = sel_src;

        if (sel_src) begin
            m_addr_o  = d_addr_i;
            m_we_o    = d_we_i;
            m_be_o    = d_be_i;
            m_wdata_o = d_wdata_i;
        end else begin
            m_addr_o  = i_addr_i;
            m_we_o    = 1'b0;
            m_be_o    = '1;
            m_wdata_o = '0;
        end
    end

    // Response routing from the FIFO head
    always_comb begin
        head_src         = fifo_q[rd_ptr_q];
        pop              = m_rvalid_i & (count_q != '0) & ~rst_i;
        i_rvalid_o       = pop & ~head_src;
        d_rvalid_o       = pop & head_src;
        r_rdata_o        = m_rdata_i;
        r_err_o          = m_err_i;
        err_unexpected_o = err_unexpected_q;
    end

    // Address-phase FSM: lock the source while a request waits for grant
    always_comb begin
        state_d    = state_q;
        hold_src_d = hold_src_q;
        last_src_d = last_src_q;
        case (state_q)
            ST_ARB: begin
                if (m_req_o && !m_gnt_i) begin
                    state_d    = ST_HOLD;
                    hold_src_d = sel_src;
                end
            end
            ST_HOLD: begin
                // A dropped request would otherwise lock the arbiter forever
                if (grant || !sel_req) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
        if (grant) begin
            last_src_d = sel_src;
        end
    end

    // Source FIFO, occupancy count and sticky unexpected-response flag
    always_comb begin
        fifo_d           = fifo_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        err_unexpected_d = err_unexpected_q;

        if (grant) begin
            fifo_d[wr_ptr_q] = sel_src;
            wr_ptr_d         = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({grant, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (m_rvalid_i && (count_q == '0)) begin
            err_unexpected_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= ST_ARB;
            hold_src_q       <= 1'b0;
            last_src_q       <= 1'b1;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= 1'b0;
            end
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            err_unexpected_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            hold_src_q       <= hold_src_d;
            last_src_q       <= last_src_d;
            fifo_q           <= fifo_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            err_unexpected_q <= err_unexpected_d;
        end
    end

endmodule

// File: tb/tb_uvmt_cv32e40x_obi_arbiter.sv
// Testbench for uvmt_cv32e40x_obi_arbiter: directed scenarios plus
// randomized OBI traffic, checked by a grant/response scoreboard fed by a
// queue-based reference model. Honors UVMT_OBI_ARB_DATA_PRIO_EN.
module tb_uvmt_cv32e40x_obi_arbiter;

    localparam int MAX = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        i_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0;
    logic [31:0] i_addr_i = '0, d_addr_i = '0, d_wdata_i = '0, m_rdata_i = '0;
    logic [3:0]  d_be_i = '0;
    logic        m_gnt_i = 1'b0, m_rvalid_i = 1'b0, m_err_i = 1'b0;
    logic        i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o, r_err_o;
    logic [31:0] r_rdata_o, m_addr_o, m_wdata_o;
    logic [3:0]  m_be_o;
    logic        m_req_o, m_we_o, m_src_o, err_unexpected_o;

    uvmt_cv32e40x_obi_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .i_req_i(i_req_i), .i_gnt_o(i_gnt_o), .i_addr_i(i_addr_i), .i_rvalid_o(i_rvalid_o),
        .d_req_i(d_req_i), .d_gnt_o(d_gnt_o), .d_addr_i(d_addr_i), .d_we_i(d_we_i),
        .d_be_i(d_be_i), .d_wdata_i(d_wdata_i), .d_rvalid_o(d_rvalid_o),
        .r_rdata_o(r_rdata_o), .r_err_o(r_err_o),
        .m_req_o(m_req_o), .m_gnt_i(m_gnt_i), .m_addr_o(m_addr_o), .m_we_o(m_we_o),
        .m_be_o(m_be_o), .m_wdata_o(m_wdata_o), .m_src_o(m_src_o),
        .m_rvalid_i(m_rvalid_i), .m_rdata_i(m_rdata_i), .m_err_i(m_err_i),
        .err_unexpected_o(err_unexpected_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          src;
        logic [31:0] addr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wd;
    } gnt_t;

    typedef struct {
        bit          src;
        logic [31:0] d;
        bit          e;
    } resp_t;

    gnt_t  exp_g[$];
    resp_t exp_r[$];

    // Reference model: list of outstanding sources in issue order
    bit outq[$];
    bit mdl_locked, mdl_lock_src, mdl_last, mdl_unexp;
    bit mdl_i_granted, mdl_d_granted;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit rst_v, input bit ir, input logic [31:0] ia,
                       input bit dr, input logic [31:0] da, input bit dw,
                       input logic [3:0] db, input logic [31:0] dd,
                       input bit g, input bit rv, input logic [31:0] rd, input bit re);
        int  size;
        bit  sel, sreq, mreq, gnt;
        @(negedge clk);
        rst_i = rst_v; i_req_i = ir; i_addr_i = ia;
        d_req_i = dr; d_addr_i = da; d_we_i = dw; d_be_i = db; d_wdata_i = dd;
        m_gnt_i = g; m_rvalid_i = rv; m_rdata_i = rd; m_err_i = re;
        #1;
        if (rst_v) begin
            chk("rst_m_req", m_req_o, 0);
            chk("rst_gnt", {i_gnt_o, d_gnt_o}, 0);
            chk("rst_rvalid", {i_rvalid_o, d_rvalid_o}, 0);
            outq.delete();
            mdl_locked = 0; mdl_lock_src = 0; mdl_last = 1; mdl_unexp = 0;
            mdl_i_granted = 0; mdl_d_granted = 0;
            return;
        end
        chk("err_unexpected", err_unexpected_o, mdl_unexp);
        size = outq.size();
        if (mdl_locked) sel = mdl_lock_src;
        else if (ir && dr) begin
`ifdef UVMT_OBI_ARB_DATA_PRIO_EN
            sel = 1;
`else
            sel = !mdl_last;
`endif
        end else sel = dr;
        sreq = sel ? dr : ir;
        mreq = sreq && (size < MAX);
        chk("m_req", m_req_o, mreq);
        if (mreq) begin
            chk("m_src", m_src_o, sel);
            chk("m_addr", m_addr_o, sel ? da : ia);
        end
        gnt = mreq && g;
        if (gnt) begin
            if (sel) exp_g.push_back('{1'b1, da, dw, db, dd});
            else     exp_g.push_back('{1'b0, ia, 1'b0, 4'hf, 32'h0});
        end
        if (rv) begin
            if (size > 0) begin
                exp_r.push_back('{outq[0], rd, re});
                void'(outq.pop_front());
            end else mdl_unexp = 1;
        end
        if (gnt) begin
            outq.push_back(sel);
            mdl_last = sel;
            mdl_locked = 0;
        end else if (mreq) begin
            mdl_locked = 1;
            mdl_lock_src = sel;
        end else mdl_locked = 0;
        mdl_i_granted = gnt && !sel;
        mdl_d_granted = gnt && sel;
    endtask

    task automatic idle(input bit rv, input logic [31:0] rd);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, rv, rd, 0);
    endtask

    task automatic do_reset();
        cyc(1, 1, 32'h44, 1, 32'h88, 0, 4'hf, 0, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pop and compare whenever the DUT shows a grant or a response
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (i_gnt_o || d_gnt_o) begin
                if (exp_g.size() == 0) chk("gnt_spurious", {i_gnt_o, d_gnt_o}, 2'b00);
                else begin
                    gnt_t e;
                    e = exp_g.pop_front();
                    chk("gnt_src", {i_gnt_o, d_gnt_o}, e.src ? 2'b01 : 2'b10);
                    chk("gnt_addr", m_addr_o, e.addr);
                    chk("gnt_we", m_we_o, e.we);
                    chk("gnt_be", m_be_o, e.be);
                    chk("gnt_wdata", m_wdata_o, e.wd);
                end
            end
            if (i_rvalid_o || d_rvalid_o) begin
                if (exp_r.size() == 0) chk("rvalid_spurious", {i_rvalid_o, d_rvalid_o}, 2'b00);
                else begin
                    resp_t e;
                    e = exp_r.pop_front();
                    chk("rvalid_src", {i_rvalid_o, d_rvalid_o}, e.src ? 2'b01 : 2'b10);
                    chk("r_rdata", r_rdata_o, e.d);
                    chk("r_err", r_err_o, e.e);
                end
            end
        end
    end

    initial begin
        bit          ir, dr, dw;
        logic [31:0] ia, da, dd;
        logic [3:0]  db;

        do_reset();

        // Single instruction fetch, response two cycles later
        cyc(0, 1, 32'h80, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(0, 0);
        idle(1, 32'h00000013);

        // Both request continuously, no responses: fill then stall
        for (int i = 0; i < 4; i++)
            cyc(0, 1, 32'h100, 1, 32'h200, 1, 4'h3, 32'hcafe, 1, 0, 0, 0);
        idle(1, 32'h11);
        idle(1, 32'h22);

        // Instruction held ungranted for three cycles while data rises
        cyc(0, 1, 32'h300, 0, 32'h400, 0, 4'hf, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h300, 1, 32'h400, 0, 4'hf, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h300, 1, 32'h400, 0, 4'hf, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h300, 1, 32'h400, 0, 4'hf, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h400, 0, 4'hf, 0, 1, 0, 0, 0);
        idle(1, 32'h33);
        // Push and pop in the same cycle at count=1, across pointer wrap
        cyc(0, 0, 0, 1, 32'h500, 1, 4'h1, 32'h5, 1, 1, 32'h44, 1);
        cyc(0, 1, 32'h600, 0, 0, 0, 0, 0, 1, 1, 32'h55, 0);
        cyc(0, 0, 0, 1, 32'h700, 0, 4'hc, 0, 1, 1, 32'h66, 0);
        idle(1, 32'h77);

        // Unexpected response sets a sticky flag, cleared only by reset
        idle(1, 32'hdead);
        for (int i = 0; i < 3; i++) idle(0, 0);
        do_reset();
        idle(0, 0);
        // Reset with a transaction in flight: its response is unexpected
        cyc(0, 1, 32'h900, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        do_reset();
        idle(1, 32'hbeef);
        idle(0, 0);
        do_reset();

`ifdef UVMT_OBI_ARB_DATA_PRIO_EN
        // Fixed priority: data wins every conflict
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 32'ha00, 1, 32'hb00 + i, 0, 4'hf, 0, 1, 0, 0, 0);
            idle(1, i);
        end
        cyc(0, 1, 32'ha00, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(1, 32'h99);
`endif

        // Randomized OBI-compliant traffic
        ir = 0; dr = 0; ia = 0; da = 0; dw = 0; db = 0; dd = 0;
        for (int n = 0; n < 3000; n++) begin
            bit g, rv;
            if (!ir || mdl_i_granted) begin
                ir = ($urandom_range(0, 99) < 60);
                ia = $urandom;
            end
            if (!dr || mdl_d_granted) begin
                dr = ($urandom_range(0, 99) < 60);
                da = $urandom; dw = $urandom_range(0, 1);
                db = 4'($urandom); dd = $urandom;
            end
            g  = ($urandom_range(0, 99) < 65);
            rv = (outq.size() > 0) && ($urandom_range(0, 99) < 45);
            cyc(0, ir, ia, dr, da, dw, db, dd, g, rv, $urandom, 1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 2 * MAX + 2; n++) idle(outq.size() > 0, $urandom);

        #10;
        chk("gnt_queue_drained", exp_g.size(), 0);
        chk("resp_queue_drained", exp_r.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uvmt_cv32e40x_obi_arbiter.md
# uvmt_cv32e40x_obi_arbiter
Two-to-one OBI arbiter for the CV32E40X testbench. It shares one memory-side OBI port between the core's instruction fetch and data ports, so the core can run against a single-ported memory model or agent. It arbitrates address phases round-robin and tracks outstanding transactions in an in-order source FIFO. It routes each response phase back to the requester that issued it.
## Interface
- ADDR_WIDTH, 32, address width of all three ports
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8
- MAX_OUTSTANDING, 2, source-FIFO depth (≥1; any integer, not only powers of two)
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- i_req_i / i_gnt_o  in/out  1  instruction-side address-phase handshake
- i_addr_i  in  ADDR_WIDTH  instruction fetch address
- i_rvalid_o  out  1  instruction-side response valid
- d_req_i / d_gnt_o  in/out  1  data-side address-phase handshake
- d_addr_i  in  ADDR_WIDTH  data address
- d_we_i  in  1  data write enable
- d_be_i  in  DATA_WIDTH/8  data byte enables
- d_wdata_i  in  DATA_WIDTH  data write data
- d_rvalid_o  out  1  data-side response valid
- r_rdata_o  out  DATA_WIDTH  shared response data (= m_rdata_i), qualified by i_rvalid_o/d_rvalid_o
- r_err_o  out  1  shared response error (= m_err_i), same qualification
- m_req_o / m_gnt_i  out/in  1  memory-side address-phase handshake
- m_addr_o, m_we_o, m_be_o, m_wdata_o  out  as above  muxed address-phase payload
- m_src_o  out  1  source of the current m_req_o: 0 = instruction, 1 = data
- m_rvalid_i  in  1  memory response valid
- m_rdata_i  in  DATA_WIDTH  memory read data
- m_err_i  in  1  memory bus error
- err_unexpected_o  out  1  sticky flag: m_rvalid_i was seen while no transaction was outstanding
## Operation
- Address-phase states:
  - ARB: source is selected combinationally this cycle.
  - HOLD: the source is locked until it is granted.
- ARB selection:
  - If only one requester is asserting req, that requester is selected.
  - If both are asserting req, the side not granted last wins (round-robin on last_src).
- Instruction transactions drive m_we_o=0, m_be_o=all ones and m_wdata_o=0.
- m_req_o = selected req AND NOT full. Here full means count == MAX_OUTSTANDING.
- When m_req_o=1 and m_gnt_i=0:
  - Enter HOLD with the source latched.
  - In HOLD the payload and m_src_o follow the latched source only.
  - The other requester is ignored, even if it has priority. This is the OBI stability rule.
- Grant: x_gnt_o = m_gnt_i & m_req_o & (selected == x). On a grant:
  - push the source into the FIFO;
  - update last_src;
  - return to ARB.
- Full: m_req_o=0 and both gnt outputs are 0. Requests wait; no grant is lost.
- Response routing:
  - When m_rvalid_i=1 and count>0, assert the rvalid of the FIFO head source and pop the FIFO.
  - Responses are strictly in order.
- Unexpected response: m_rvalid_i=1 with count==0 sets err_unexpected_o. Nothing is routed, and no pointer or count changes. The flag is cleared only by reset.
- Simultaneous grant and rvalid:
  - push and pop in the same cycle; count is unchanged.
  - The full check uses the pre-update count, so there is no same-cycle slot reuse.
- Pointers wrap from MAX_OUTSTANDING-1 to 0. count is $clog2(MAX_OUTSTANDING+1) bits wide.
- Reset values:
  - state=ARB, count=0, pointers=0, err_unexpected_o=0.
  - last_src=data, so the first conflict after reset goes to instruction.
  - While rst_i=1: m_req_o, i_gnt_o, d_gnt_o, i_rvalid_o and d_rvalid_o are forced to 0.
- Reset mid-operation drops all outstanding tracking. Any in-flight responses after reset are flagged as unexpected.
## Timing
- Address phase has zero added latency: m_req_o and payload are combinational from the inputs in ARB, and gnt is combinational from m_gnt_i.
- Response phase has zero added latency: x_rvalid_o, r_rdata_o and r_err_o are combinational from the m_* inputs and the registered FIFO head.
- All state (state, latched source, last_src, FIFO, count, flag) updates on the rising edge of clk_i.
- Sustained throughput is one grant per cycle while not full.
## Configuration
- UVMT_OBI_ARB_DATA_PRIO_EN:
  - Defined: fixed priority; data wins every conflict in ARB, and last_src is unused. HOLD behaviour is unchanged.
  - Undefined (default): round-robin as described above.
## Test plan
- Single instruction request, addr 0x80, m_gnt_i=1 same cycle, rvalid 2 cycles later with rdata 0x00000013:
  - i_gnt_o pulses in the same cycle and m_src_o=0.
  - i_rvalid_o=1 with r_rdata_o=0x13; d_rvalid_o stays 0.
- Both sides request continuously with m_gnt_i=1 and responses never returned (stall):
  - Grants go I, D, then stop because the FIFO is full (MAX_OUTSTANDING=2), with m_req_o=0.
  - Returning 2 responses routes them I then D.
- Instruction requests, m_gnt_i held 0 for 3 cycles, data request raised in cycle 1:
  - m_src_o stays 0 and the address stays stable for all 3 cycles.
  - Instruction is granted first; data is granted on the next cycle.
- Push and pop in the same cycle at count=1:
  - count stays 1 and the routing order is preserved across pointer wrap.
- m_rvalid_i=1 with nothing outstanding:
  - err_unexpected_o becomes 1 and holds until rst_i.
  - Both rvalid outputs stay 0.
- With UVMT_OBI_ARB_DATA_PRIO_EN defined and both sides requesting 4 times: data is granted 4 times before any instruction grant.
